serial_alu_ctrl: RTL and testbench

Bit-serial sequencer for the team's 1-bit ALU slice. It latches two WIDTH-bit operands and an op code on `start`, then feeds one bit pair per clock, LSB first, through a single slice instance. The slice's `e` output is registered and fed back as the next bit's `c` input. After WIDTH cycles it presents the WIDTH-bit result and a carry/flag bit. It sits between the lab top level (switch/button inputs) and the shared 1-bit ALU datapath.

---
 rtl/serial_alu_pkg.sv | 19 +
 rtl/alu_bit_slice.sv | 32 +++
 rtl/serial_alu_ctrl.sv | 118 +++++++++++
 tb/tb_serial_alu_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_alu_pkg.sv
// Shared constants and state encoding for the bit-serial ALU sequencer.
package serial_alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice: d is the result bit, e the carry/flag out.
module alu_bit_slice
  import serial_alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic [1:0] op,
  output logic       d,
  output logic       e
);

  always_comb begin
    d = 1'b0;
    e = 1'b0;
    case (op)
      OP_ADD: begin
        d = a ^ b ^ c;
        e = maj(a, b, c);
      end
      OP_AND: d = a & b;
      // Compare is an add of ~b: only the carry chain is kept.
      OP_CMP: e = maj(a, ~b, c);
      OP_XOR: d = a ^ b;
      default: begin
        d = 1'b0;
        e = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial sequencer driving one alu_bit_slice LSB first over WIDTH cycles.
// Optional zero flag output enabled by defining SERIAL_ALU_ZERO_FLAG_EN.
module serial_alu_ctrl
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef SERIAL_ALU_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, shift_reg, result_reg;
  logic [WIDTH-1:0] shift_next;
  logic [CW-1:0]    cnt_reg;
  logic [1:0]       op_reg;
  logic             carry_reg, cout_reg;
  logic             slice_d, slice_e;
  logic             accept, last_bit;

  alu_bit_slice u_slice (
    .a  (a_reg[0]),
    .b  (b_reg[0]),
    .c  (carry_reg),
    .op (op_reg),
    .d  (slice_d),
    .e  (slice_e)
  );

  assign accept     = (state_reg == ST_IDLE) && start;
  assign last_bit   = (cnt_reg == CW'(WIDTH - 1));
  assign shift_next = {slice_d, shift_reg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (last_bit) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      shift_reg  <= '0;
      result_reg <= '0;
      cnt_reg    <= '0;
      op_reg     <= OP_ADD;
      carry_reg  <= 1'b0;
      cout_reg   <= 1'b0;
    end else if (accept) begin
      a_reg     <= a_in;
      b_reg     <= b_in;
      op_reg    <= op;
      carry_reg <= (op == OP_ADD || op == OP_CMP) ? cin : 1'b0;
      cnt_reg   <= '0;
      shift_reg <= '0;
    end else if (state_reg == ST_RUN) begin
      shift_reg <= shift_next;
      carry_reg <= slice_e;
      a_reg     <= a_reg >> 1;
      b_reg     <= b_reg >> 1;
      cnt_reg   <= cnt_reg + CW'(1);
      // Final bit: publish the completed word on the same edge it finishes.
      if (last_bit) begin
        result_reg <= shift_next;
        cout_reg   <= slice_e;
      end
    end
  end

`ifdef SERIAL_ALU_ZERO_FLAG_EN
  logic any_reg, zero_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_reg  <= 1'b0;
      zero_reg <= 1'b1;
    end else if (accept) begin
      any_reg <= 1'b0;
    end else if (state_reg == ST_RUN) begin
      any_reg <= any_reg | slice_d;
      if (last_bit) zero_reg <= ~(any_reg | slice_d);
    end
  end

  assign zero = zero_reg;
`endif

  assign busy   = (state_reg != ST_IDLE);
  assign done   = (state_reg == ST_DONE);
  assign result = result_reg;
  assign cout   = cout_reg;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Scoreboard bench for serial_alu_ctrl: random and directed ops vs. an arithmetic model.
module tb_serial_alu_ctrl;

  localparam int WIDTH = 8;
  localparam longint MASK = (64'd1 << WIDTH) - 1;

  logic             clk, rst_n, start, cin;
  logic [1:0]       op;
  logic [WIDTH-1:0] a_in, b_in, result;
  logic             busy, done, cout;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
  logic             zero;
`endif

  serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a_in   (a_in),
    .b_in   (b_in),
    .cin    (cin),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    ,
    .zero   (zero)
`endif
  );

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             co;
    logic             zf;
    int               done_cyc;
    string            tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on whole operands.
  function automatic exp_t model(input logic [1:0] o, input longint a, input longint b,
                                 input longint c, input string tag);
    exp_t   e;
    longint s;
    s = 0;
    e.co = 1'b0;
    case (o)
      2'b00: begin s = a + b + c; e.co = s[WIDTH]; s = s & MASK; end
      2'b01: s = a & b;
      2'b10: begin s = a + ((~b) & MASK) + c; e.co = s[WIDTH]; s = 0; end
      default: s = a ^ b;
    endcase
    e.res = s[WIDTH-1:0];
    e.zf = (s == 0);
    e.done_cyc = 0;
    e.tag = tag;
    return e;
  endfunction

  // Monitor: every done pulse consumes one expected entry.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, required no pending op");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_result"}, result, e.res);
        check({e.tag, "_cout"}, cout, e.co);
`ifdef SERIAL_ALU_ZERO_FLAG_EN
        check({e.tag, "_zero"}, zero, e.zf);
`endif
        check({e.tag, "_done_cycle"}, cyc, e.done_cyc);
        check({e.tag, "_busy_in_done"}, busy, 1);
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic c, input string tag);
    exp_t e;
    @(negedge clk);
    op = o; a_in = a; b_in = b; cin = c; start = 1'b1;
    @(posedge clk);
    #1;
    e = model(o, longint'(a), longint'(b), longint'(c), tag);
    e.done_cyc = cyc + WIDTH;
    sb.push_back(e);
    start = 1'b0;
    op = ~o; a_in = ~a; b_in = ~b; cin = ~c;
    $display("op %s: op=%0d a=%0h b=%0h cin=%0d -> exp result=%0h cout=%0d",
             tag, o, a, b, c, e.res, e.co);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < WIDTH + 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic c, input string tag);
    int n;
    issue(o, a, b, c, tag);
    check({tag, "_busy_after_accept"}, busy, 1);
    wait_idle(n);
    check({tag, "_busy_cycles"}, n, WIDTH + 1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a_in = '0; b_in = '0; cin = 1'b0;
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    check("reset_cout", cout, 0);
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    check("reset_zero", zero, 1);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(2'b00, 8'h5A, 8'h3C, 1'b0, "add_5a_3c");
    run_op(2'b00, 8'hFF, 8'h01, 1'b0, "add_ff_01");
    run_op(2'b10, 8'h40, 8'h3F, 1'b1, "cmp_40_3f");
    run_op(2'b10, 8'h3F, 8'h40, 1'b1, "cmp_3f_40");
    run_op(2'b10, 8'h55, 8'h55, 1'b1, "cmp_eq_c1");
    run_op(2'b10, 8'h55, 8'h55, 1'b0, "cmp_eq_c0");
    run_op(2'b01, 8'hF0, 8'h3C, 1'b1, "and_f0_3c");
    run_op(2'b11, 8'hF0, 8'h3C, 1'b1, "xor_f0_3c");

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), WIDTH'($urandom), WIDTH'($urandom),
             1'($urandom), $sformatf("rnd%0d", i));
    end

    // Start pulses during RUN must be ignored and never queued.
    issue(2'b00, 8'h12, 8'h34, 1'b0, "midrun_add");
    @(negedge clk);
    @(negedge clk);
    op = 2'b11; a_in = 8'hAA; b_in = 8'h55; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("midrun_busy", busy, 1);
    wait_idle(n);
    repeat (WIDTH + 3) @(posedge clk);
    #1;
    check("midrun_no_queue", busy, 0);

    // Leave a nonzero result with cout=1 so the reset clear is observable.
    run_op(2'b00, 8'hFF, 8'h02, 1'b0, "add_ff_02");
    issue(2'b00, 8'h5A, 8'h3C, 1'b0, "aborted_add");
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_cout", cout, 0);
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    check("abort_zero", zero, 1);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'b00, 8'h01, 8'h01, 1'b0, "post_reset_add");

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
